sram_readback: RTL and testbench
================================

SRAM_READBACK -- requirements
Module: sram_readback

Interface
REQ-001 Parameter: A_WIDTH, default 13, SRAM address width in bits.
REQ-002 Parameter: D_WIDTH, default 8, SRAM data width in bits.
REQ-003 Clk  input  1  sole clock; all logic on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 Go  input  1  start request; sampled only in IDLE.
REQ-006 Start_Addr  input  A_WIDTH  first SRAM address to read; sampled with Go.
REQ-007 Len  input  A_WIDTH+1  number of words to read, 0..2**A_WIDTH; sampled with Go.
REQ-008 Mem_Addr  output  A_WIDTH  SRAM address.
REQ-009 Mem_En  output  1  SRAM enable; high for exactly one cycle per read issued.
REQ-010 Mem_Rw  output  1  SRAM read/write select; tied 0 (read) at all times.
REQ-011 Mem_Data  input  D_WIDTH  SRAM read data; valid exactly one cycle after the Mem_En cycle.
REQ-012 Out_Data  output  D_WIDTH  streamed read word.
REQ-013 Out_Valid  output  1  Out_Data holds a word.
REQ-014 Out_Ready  input  1  consumer accepts the word when Out_Valid and Out_Ready are both high.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-018 IDLE: Go=1 with Len!=0 -> READ; Go=1 with Len=0 -> DONE; otherwise stay in IDLE.
REQ-019 READ: one read is issued per cycle while (buffered words + in-flight reads) < 2; after issuing the Len-th read -> DRAIN.
REQ-020 The read address SHALL start at Start_Addr, increment by 1 per issued read, and wrap modulo 2**A_WIDTH (8191 -> 0).
REQ-021 Each Mem_Data word SHALL be captured into a 2-entry FIFO on the cycle after its Mem_En; the word is never dropped.
REQ-022 Out_Valid SHALL equal FIFO not-empty; Out_Data SHALL be the FIFO head; words leave in address order.
REQ-023 DRAIN: when the FIFO is empty and no read is in flight -> DONE.
REQ-024 DONE: Done=1 for one cycle, then -> IDLE.
REQ-025 Go outside IDLE SHALL be ignored.
REQ-026 Throughput: with Out_Ready held high, exactly one word per cycle; first Out_Valid 2 cycles after the Go cycle.
REQ-027 Out_Ready low for any duration SHALL stall issue within the credit limit, with no loss or duplication.
REQ-028 In the FIFO, a simultaneous push and pop at count 2 is impossible by construction; at count 1 the count stays 1.

Reset
REQ-029 Rst=0 at a clock edge SHALL force: state IDLE, FIFO empty, in-flight cleared, Mem_En=0, Mem_Addr=0, Out_Valid=0, Busy=0, Done=0.
REQ-030 Rst asserted mid-transfer SHALL abort the transfer without a Done pulse; a read in flight is discarded.

Configuration
REQ-031 Macro READBACK_SUM_EN: when defined, add output Sum (16 bits) = modulo-2**16 sum of all words accepted on the output since the last Go; Sum is cleared on Go and on reset, and holds its value after Done.
REQ-032 Without READBACK_SUM_EN, the Sum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The shared package SHALL hold the A_WIDTH/D_WIDTH defaults, the FSM state encoding, and the FIFO depth constant (2).
REQ-034 Sub-module readback_fifo (2-deep, D_WIDTH wide, push/pop/count) SHALL implement the output buffer.

Verification
REQ-035 Memory preloaded with mem[a]=a[7:0]; Go, Start_Addr=0, Len=8192, Out_Ready=1 -> 8192 words 00..FF repeating, one per cycle; Done pulses once.
REQ-036 Start_Addr=8190, Len=4 -> words at addresses 8190, 8191, 0, 1 in that order.
REQ-037 Len=0 -> no Mem_En; Done one cycle after Go; Out_Valid stays 0.
REQ-038 Len=16, Out_Ready toggled pseudo-randomly (including 10-cycle low bursts) -> the same 16 words in order, no duplicates, Mem_En never issued beyond 2 outstanding words.
REQ-039 Rst pulled low on the 5th cycle of a Len=100 transfer -> all outputs at reset values next cycle; no Done; a new Go then runs correctly.
REQ-040 With READBACK_SUM_EN: words 01,02,FF,FF -> Sum=0x0201 at Done.

Source files
------------

// File: rtl/sram_readback_pkg.sv
// sram_readback_pkg
// Shared definitions for the SRAM read-back streamer: default address/data
// widths, the FSM state encoding and the output buffer depth.
package sram_readback_pkg;

  localparam int A_WIDTH_DEF = 13;
  localparam int D_WIDTH_DEF = 8;

  // Output buffer depth; also the issue credit limit (buffered + in-flight).
  localparam int FIFO_DEPTH  = 2;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/readback_fifo.sv
// readback_fifo
// Two-entry output buffer for the read-back streamer.
// Ports:
//   Clk   - clock, rising edge
//   Rst   - synchronous active-low reset (pointers and count only)
//   push  - write din this cycle
//   pop   - remove the head this cycle
//   din   - word to write
//   dout  - current head word
//   count - number of buffered words (0..2)
//   empty - count is zero
module readback_fifo
  import sram_readback_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               push,
  input  logic               pop,
  input  logic [D_WIDTH-1:0] din,
  output logic [D_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]   count,
  output logic               empty
);

  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  // Two entries, so each pointer is a single toggling bit.
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      // The issuer never lets a push meet a full buffer, so push+pop only
      // ever happens at count 1 and leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/sram_readback.sv
// sram_readback
// Reads Len consecutive words from a synchronous SRAM starting at Start_Addr
// (address wraps at 2**A_WIDTH) and streams them out with valid/ready flow
// control through a 2-entry buffer. Reads are issued only while buffered plus
// in-flight words stay below the buffer depth, so no word is ever dropped.
// Optional feature: define READBACK_SUM_EN to add the Sum output, a 16-bit
// running sum of words accepted on the output since the last accepted Go.
// Ports:
//   Clk, Rst          - clock, synchronous active-low reset
//   Go                - start request (only honoured in IDLE)
//   Start_Addr, Len   - first address and word count, sampled with Go
//   Mem_Addr, Mem_En  - SRAM address and one-cycle read enable
//   Mem_Rw            - SRAM read/write select, always read (0)
//   Mem_Data          - SRAM read data, valid the cycle after Mem_En
//   Out_Data/Valid    - streamed word and its valid flag
//   Out_Ready         - consumer accept
//   Busy              - not in IDLE
//   Done              - one-cycle pulse at the end of a transfer
//   Sum               - (READBACK_SUM_EN only) accepted-word sum
module sram_readback
  import sram_readback_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [A_WIDTH-1:0] Start_Addr,
  input  logic [A_WIDTH:0]   Len,
  output logic [A_WIDTH-1:0] Mem_Addr,
  output logic               Mem_En,
  output logic               Mem_Rw,
  input  logic [D_WIDTH-1:0] Mem_Data,
  output logic [D_WIDTH-1:0] Out_Data,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic               Busy,
  output logic               Done
`ifdef READBACK_SUM_EN
  ,
  output logic [15:0]        Sum
`endif
);

  localparam int OUT_W = CNT_W + 1;

  state_t             state;
  logic [A_WIDTH-1:0] addr;
  logic [A_WIDTH:0]   remaining;
  logic               inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               pop;
  logic               start;
  logic               go_read;
  logic               issue;
  logic [OUT_W-1:0]   outstanding;

  assign start   = Rst && (state == ST_IDLE) && Go;
  assign go_read = start && (Len != '0);
  assign pop     = !fifo_empty && Out_Ready;

  // Words that will still occupy the buffer next cycle without a new read;
  // a pop this cycle frees a credit so steady state reaches one word/cycle.
  assign outstanding = OUT_W'(fifo_count) + OUT_W'(inflight) - OUT_W'(pop);

  // The first read goes out in the Go cycle itself, straight from Start_Addr.
  assign issue = go_read ||
                 (Rst && (state == ST_READ) && (remaining != '0) &&
                  (outstanding < OUT_W'(FIFO_DEPTH)));

  assign Mem_En   = issue;
  assign Mem_Addr = ((state == ST_IDLE) && Go) ? Start_Addr : addr;
  assign Mem_Rw   = 1'b0;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      inflight <= issue;
      Done     <= 1'b0;
      if (issue) addr <= Mem_Addr + A_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (Go) begin
            Busy <= 1'b1;
            if (Len != '0) begin
              remaining <= Len - (A_WIDTH + 1)'(1);
              state     <= ST_READ;
            end else begin
              Done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (issue) remaining <= remaining - (A_WIDTH + 1)'(1);
          if ((remaining == '0) || (issue && remaining == (A_WIDTH + 1)'(1)))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty && !inflight) begin
            Done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data returns the cycle after its enable; inflight marks that cycle.
  readback_fifo #(
    .D_WIDTH(D_WIDTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (inflight),
    .pop   (pop),
    .din   (Mem_Data),
    .dout  (Out_Data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign Out_Valid = !fifo_empty;

`ifdef READBACK_SUM_EN
  always_ff @(posedge Clk) begin
    if (!Rst || start) Sum <= '0;
    else if (pop)      Sum <= Sum + 16'(Out_Data);
  end
`endif

endmodule

// File: tb/tb_sram_readback.sv
// tb_sram_readback
// Bench for sram_readback: SRAM behavioural model, expected-word queues built
// from the memory image, and a negedge monitor that checks every read address,
// every accepted word, the issue credit and the Done pulses.
module tb_sram_readback;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          Clk;
  logic          Rst;
  logic          Go;
  logic [AW-1:0] Start_Addr;
  logic [AW:0]   Len;
  logic [AW-1:0] Mem_Addr;
  logic          Mem_En;
  logic          Mem_Rw;
  logic [DW-1:0] Mem_Data;
  logic [DW-1:0] Out_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic          Busy;
  logic          Done;
`ifdef READBACK_SUM_EN
  logic [15:0]   Sum;
  logic [15:0]   sum_model;
`endif

  sram_readback #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Go         (Go),
    .Start_Addr (Start_Addr),
    .Len        (Len),
    .Mem_Addr   (Mem_Addr),
    .Mem_En     (Mem_En),
    .Mem_Rw     (Mem_Rw),
    .Mem_Data   (Mem_Data),
    .Out_Data   (Out_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Busy       (Busy),
    .Done       (Done)
`ifdef READBACK_SUM_EN
    ,
    .Sum        (Sum)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: data appears the cycle after the enable; garbage otherwise.
  logic [DW-1:0] mem [0:DEPTH-1];
  initial Mem_Data = '0;
  always @(posedge Clk) Mem_Data <= Mem_En ? mem[Mem_Addr] : DW'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int          cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int          exp_addr [$];
  logic [DW-1:0] exp_data [$];
  int          issued, accepted, done_cnt, first_acc, last_acc;
  initial begin
    issued = 0; accepted = 0; done_cnt = 0; first_acc = -1; last_acc = -1;
`ifdef READBACK_SUM_EN
    sum_model = '0;
`endif
  end

  always @(negedge Clk) begin
    if (Rst) begin
      logic pop_now;
      pop_now = Out_Valid && Out_Ready;
      if (Go && !Busy) begin
        issued = 0; accepted = 0; first_acc = -1; last_acc = -1;
`ifdef READBACK_SUM_EN
        sum_model = '0;
`endif
      end
      if (Mem_En) begin
        check("credit_ok", 32'((issued - accepted - int'(pop_now) + 1) <= 2), 32'd1);
        check("mem_rw", 32'(Mem_Rw), 32'd0);
        if (exp_addr.size() == 0) check("extra_read", 32'd1, 32'd0);
        else check("mem_addr", 32'(Mem_Addr), 32'(exp_addr.pop_front()));
        issued++;
      end
      if (pop_now) begin
        if (exp_data.size() == 0) check("extra_word", 32'd1, 32'd0);
        else check("out_data", 32'(Out_Data), 32'(exp_data.pop_front()));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        accepted++;
`ifdef READBACK_SUM_EN
        sum_model = sum_model + 16'(Out_Data);
`endif
      end
      if (Done) begin
        done_cnt++;
        check("done_all_out", 32'(exp_data.size()), 32'd0);
      end
    end
  end

  task automatic prep(input int start, input int len);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((start + i) % DEPTH);
      exp_data.push_back(mem[(start + i) % DEPTH]);
    end
  endtask

  task automatic run(input int start, input int len, input bit rnd);
    int budget;
    int done0;
    int burst;
    budget = 0;
    burst  = 0;
    done0  = done_cnt;
    prep(start, len);
    Out_Ready  = 1'b1;
    Start_Addr = AW'(start);
    Len        = (AW + 1)'(len);
    Go         = 1'b1;
    @(posedge Clk); #1;
    Go         = 1'b0;
    Start_Addr = AW'($urandom);
    Len        = (AW + 1)'($urandom);
    if (!rnd) begin
      @(negedge Clk);
      if (len == 0) check("len0_done", 32'(Done), 32'd1);
      else          check("lat_valid_early", 32'(Out_Valid), 32'd0);
      if (len != 0) begin
        @(negedge Clk);
        check("lat_valid_2", 32'(Out_Valid), 32'd1);
      end
    end
    do begin
      @(posedge Clk); #1;
      budget++;
      if (rnd) begin
        if (burst > 0) begin
          Out_Ready = 1'b0;
          burst--;
        end else if ($urandom_range(0, 11) == 0) begin
          Out_Ready = 1'b0;
          burst = 9;
        end else begin
          Out_Ready = 1'($urandom);
        end
        // Stray Go pulses while busy must be ignored.
        Go = Busy && ($urandom_range(0, 5) == 0);
      end
    end while (done_cnt == done0 && budget < len * 8 + 100);
    Go        = 1'b0;
    Out_Ready = 1'b1;
    if (done_cnt == done0) check("timeout", 32'd1, 32'd0);
    check("busy_after", 32'(Busy), 32'd0);
    check("done_low_after", 32'(Done), 32'd0);
    check("issued", 32'(issued), 32'(len));
    check("accepted", 32'(accepted), 32'(len));
    if (!rnd && len != 0) check("throughput", 32'(last_acc - first_acc + 1), 32'(len));
`ifdef READBACK_SUM_EN
    check("sum", 32'(Sum), 32'(sum_model));
`endif
    repeat (3) @(posedge Clk);
    #1;
    check("done_once", 32'(done_cnt - done0), 32'd1);
  endtask

  initial begin
    int done0;
    Rst = 1'b0; Go = 1'b0; Start_Addr = '0; Len = '0; Out_Ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) mem[a] = a[DW-1:0];
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_mem_en", 32'(Mem_En), 32'd0);
    check("rst_mem_addr", 32'(Mem_Addr), 32'd0);
    check("rst_valid", 32'(Out_Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Full sweep with the identity image, consumer always ready.
    run(0, DEPTH, 1'b0);

    for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);

    run(DEPTH - 2, 4, 1'b0);   // address wrap
    run(0, 0, 1'b0);           // empty transfer
    run(5, 1, 1'b0);           // single word
    run(1234, 16, 1'b1);       // back-pressure with long stalls
    for (int k = 0; k < 6; k++)
      run($urandom_range(DEPTH - 20, DEPTH - 1) * (k % 2) + $urandom_range(0, 200),
          $urandom_range(1, 40), 1'b1);

    // Abort a transfer with reset partway through.
    done0 = done_cnt;
    prep(50, 100);
    Out_Ready = 1'b1; Start_Addr = AW'(50); Len = (AW + 1)'(100); Go = 1'b1;
    @(posedge Clk); #1;
    Go = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    Rst = 1'b0;
    @(posedge Clk); #1;
    exp_addr.delete();
    exp_data.delete();
    Rst = 1'b1;
    @(negedge Clk);
    check("abort_mem_en", 32'(Mem_En), 32'd0);
    check("abort_mem_addr", 32'(Mem_Addr), 32'd0);
    check("abort_valid", 32'(Out_Valid), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    repeat (4) @(negedge Clk);
    check("abort_valid_later", 32'(Out_Valid), 32'd0);
    check("abort_no_done", 32'(done_cnt - done0), 32'd0);
    @(posedge Clk); #1;
    run(8000, 30, 1'b1);

`ifdef READBACK_SUM_EN
    mem[300] = 8'h01; mem[301] = 8'h02; mem[302] = 8'hFF; mem[303] = 8'hFF;
    run(300, 4, 1'b0);
    check("sum_0201", 32'(Sum), 32'h0201);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
